// File: rtl/ibex_instr_arbiter.sv
// Two-requester arbiter that shares one in-order req/gnt/rvalid instruction port.
// An ID FIFO records who was granted, so each response is routed back to its issuer.
module ibex_instr_arbiter #(
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned MemDataWidth   = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [1:0]              req_i,
   input  logic [31:0]             addr0_i,
   input  logic [31:0]             addr1_i,
   output logic [1:0]              gnt_o,
   output logic [1:0]              rvalid_o,
   output logic [MemDataWidth-1:0] rdata_o,
   output logic                    err_o,
   output logic                    instr_req_o,
   output logic [31:0]             instr_addr_o,
   input  logic                    instr_gnt_i,
   input  logic                    instr_rvalid_i,
   input  logic [MemDataWidth-1:0] instr_rdata_i,
   input  logic                    instr_err_i,
   output logic                    busy_o,
   output logic                    spurious_rvalid_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   logic            r_lock_vld;
   logic            r_lock_id;
   logic            r_last;
   logic [CntW-1:0] r_count;
   logic [PtrW-1:0] r_wr_ptr;
   logic [PtrW-1:0] r_rd_ptr;
   logic            r_fifo [MaxOutstanding];

   logic w_full;
   logic w_sel;
   logic w_grant;
   logic w_resp;
   logic w_head;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_sel = req_i[1];
      if (r_lock_vld) begin
         w_sel = r_lock_id;
      end else if (&req_i) begin
         w_sel = ~r_last;
      end
   end

   assign w_full       = (r_count == CntW'(MaxOutstanding));
   assign instr_req_o  = ~w_full & (r_lock_vld | (|req_i));
   assign instr_addr_o = w_sel ? addr1_i : addr0_i;
   assign w_grant      = instr_req_o & instr_gnt_i;
   assign w_head       = r_fifo[r_rd_ptr];
   // A response only counts when something is outstanding; otherwise it is flagged.
   assign w_resp       = instr_rvalid_i & (r_count != '0);

   always_comb begin
      gnt_o    = 2'b00;
      rvalid_o = 2'b00;
      if (w_grant) gnt_o[w_sel] = 1'b1;
      if (w_resp)  rvalid_o[w_head] = 1'b1;
   end

   assign rdata_o           = instr_rdata_i;
   assign err_o             = w_resp & instr_err_i;
   assign busy_o            = (r_count != '0);
   assign spurious_rvalid_o = instr_rvalid_i & (r_count == '0);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lock_vld <= 1'b0;
         r_lock_id  <= 1'b0;
         r_last     <= 1'b1;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         if (w_grant) begin
            r_lock_vld <= 1'b0;
            r_last     <= w_sel;
            r_wr_ptr   <= ptr_inc(r_wr_ptr);
         end else if (instr_req_o) begin
            r_lock_vld <= 1'b1;
            r_lock_id  <= w_sel;
         end
         if (w_resp) r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_grant, w_resp})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; entries are only read when r_count says they are valid.
   always_ff @(posedge clk_i) begin
      if (w_grant) r_fifo[r_wr_ptr] <= w_sel;
   end

endmodule
